// File: rtl/fp_pkg.sv
// Shared constants and width helpers for the fixed-point add/sub pipeline.
package fp_pkg;

  localparam int SAT_WRAP   = 0;
  localparam int SAT_CLAMP  = 1;
  localparam int RND_TRUNC  = 0;
  localparam int RND_HALFUP = 1;

  function automatic int fp_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One extra integer bit so A+B / A-B can never overflow internally.
  function automatic int fp_wi(input int wi1, input int wi2);
    return fp_max(wi1, wi2) + 1;
  endfunction

  function automatic int fp_wf(input int wf1, input int wf2);
    return fp_max(wf1, wf2);
  endfunction

  // Largest positive two's complement code of width w, as raw bits.
  function automatic logic [63:0] fp_max_code(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's complement code of width w, as raw bits.
  function automatic logic [63:0] fp_min_code(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/fp_round_sat.sv
// Stage-2 datapath: reduce a full-precision sum to the output format,
// rounding or truncating the fraction and clamping or wrapping the integer.
module fp_round_sat
  import fp_pkg::*;
#(
  parameter int WI  = 9,
  parameter int WF  = 10,
  parameter int WIO = 8,
  parameter int WFO = 8,
  parameter int SAT = 1,
  parameter int RND = 1
) (
  input  logic [WI+WF-1:0]   sum_i,
  output logic [WIO+WFO-1:0] out_o,
  output logic               ovf_o
);

  localparam int WO = WIO + WFO;
  // Generous working width: holds any sum rescaled to WFO plus the rounding
  // carry, and is wide enough to represent the output range for compares.
  localparam int RW = fp_max(WI, WIO) + WF + WFO + 2;

  localparam logic signed [RW-1:0] MAXV = RW'(fp_max_code(WO));
  localparam logic signed [RW-1:0] MINV = -$signed(RW'(fp_min_code(WO)));
  localparam logic [WO-1:0]        MAXC = WO'(fp_max_code(WO));
  localparam logic [WO-1:0]        MINC = WO'(fp_min_code(WO));

  logic signed [RW-1:0] s_ext;
  logic signed [RW-1:0] r;   // result as an integer count of 2^-WFO units

  assign s_ext = RW'($signed(sum_i));

  generate
    if (WFO >= WF) begin : g_pad
      assign r = s_ext <<< (WFO - WF);
    end else begin : g_reduce
      localparam int SH = WF - WFO;
      if (RND == RND_HALFUP) begin : g_rnd
        // Add half an output LSB then floor: ties go toward +inf.
        localparam logic signed [RW-1:0] HALF = RW'(1) << (SH - 1);
        assign r = (s_ext + HALF) >>> SH;
      end else begin : g_trunc
        assign r = s_ext >>> SH;
      end
    end
  endgenerate

  // Range check against the output format, then clamp or wrap.
  always_comb begin
    ovf_o = (r > MAXV) || (r < MINV);
    out_o = r[WO-1:0];
    if (ovf_o && (SAT == SAT_CLAMP))
      out_o = r[RW-1] ? MINC : MAXC;
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Two-stage fixed-point adder/subtractor with valid/ready handshake,
// output rounding/saturation and overflow monitoring.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int WI1  = 8,
  parameter int WF1  = 10,
  parameter int WI2  = 8,
  parameter int WF2  = 10,
  parameter int WIO  = 8,
  parameter int WFO  = 8,
  parameter int SAT  = 1,
  parameter int RND  = 1,
  parameter int CNTW = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WI1+WF1-1:0]   A,
  input  logic [WI2+WF2-1:0]   B,
  input  logic                 op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIO+WFO-1:0]   out,
  output logic                 ovf,
  output logic                 ovf_sticky,
  input  logic                 ovf_clr,
  output logic [CNTW-1:0]      ovf_cnt
);

  localparam int WI = fp_wi(WI1, WI2);
  localparam int WF = fp_wf(WF1, WF2);
  localparam int W  = WI + WF;
  localparam int WO = WIO + WFO;

  // vld_pipe_q[1] = stage-1 slot, vld_pipe_q[2] = output register.
  logic [2:1]           vld_pipe_q;
  logic signed [W-1:0]  a_al, b_al, sum_d, sum_q;
  logic [WO-1:0]        rs_out, out_q;
  logic                 rs_ovf, ovf_q;
  logic                 ovf_sticky_q, ovf_sticky_d;
  logic [CNTW-1:0]      ovf_cnt_q, ovf_cnt_d;
  logic                 adv1, adv2, ovf_hit;

  // Stage 2 moves when the output is empty or being taken; stage 1 moves
  // when its slot is empty or stage 2 moves.
  assign adv2     = !vld_pipe_q[2] || out_ready;
  assign adv1     = !vld_pipe_q[1] || adv2;
  assign in_ready = adv1;

  // Full-precision alignment: sign-extend, then zero-pad the fraction.
  assign a_al  = W'($signed(A)) <<< (WF - WF1);
  assign b_al  = W'($signed(B)) <<< (WF - WF2);
  assign sum_d = op ? (a_al - b_al) : (a_al + b_al);

  fp_round_sat #(
    .WI (WI),
    .WF (WF),
    .WIO(WIO),
    .WFO(WFO),
    .SAT(SAT),
    .RND(RND)
  ) u_round_sat (
    .sum_i(sum_q),
    .out_o(rs_out),
    .ovf_o(rs_ovf)
  );

  // Pipeline registers: each stage loads only when it advances, so a
  // stalled output holds out/ovf stable.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_pipe_q <= '0;
      sum_q      <= '0;
      out_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (adv1) begin
        vld_pipe_q[1] <= in_valid;
        if (in_valid) sum_q <= sum_d;
      end
      if (adv2) begin
        vld_pipe_q[2] <= vld_pipe_q[1];
        if (vld_pipe_q[1]) begin
          out_q <= rs_out;
          ovf_q <= rs_ovf;
        end
      end
    end
  end

  assign ovf_hit = vld_pipe_q[2] && out_ready && ovf_q;

  // Overflow monitor next state: clear first so a coincident overflow beat
  // lands on a fresh count of one.
  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    ovf_cnt_d    = ovf_cnt_q;
    if (ovf_clr) begin
      ovf_sticky_d = 1'b0;
      ovf_cnt_d    = '0;
    end
    if (ovf_hit) begin
      ovf_sticky_d = 1'b1;
      if (ovf_cnt_d != '1) ovf_cnt_d = ovf_cnt_d + CNTW'(1);
    end
  end

  // Overflow monitor registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf_sticky_q <= 1'b0;
      ovf_cnt_q    <= '0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
      ovf_cnt_q    <= ovf_cnt_d;
    end
  end

  assign out_valid  = vld_pipe_q[2];
  assign out        = out_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = ovf_sticky_q;
  assign ovf_cnt    = ovf_cnt_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: default (SAT=1,RND=1), wrap (SAT=0)
// and truncate (RND=0) instances share one stimulus stream.
module tb_fp_addsub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, in_valid, op, out_ready, ovf_clr;
  logic [17:0] A, B;

  logic        in_ready, out_valid, ovf, ovf_sticky;
  logic [15:0] out;
  logic [7:0]  ovf_cnt;
  logic        in_ready_w, out_valid_w, ovf_w, ovf_sticky_w;
  logic [15:0] out_w;
  logic [7:0]  ovf_cnt_w;
  logic        in_ready_t, out_valid_t, ovf_t, ovf_sticky_t;
  logic [15:0] out_t;
  logic [7:0]  ovf_cnt_t;

  int n_chk = 0;
  int n_pass = 0;

  fp_addsub_pipe dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .ovf(ovf), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr),
    .ovf_cnt(ovf_cnt));

  fp_addsub_pipe #(.SAT(0)) dut_w (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_w),
    .A(A), .B(B), .op(op), .out_valid(out_valid_w), .out_ready(out_ready),
    .out(out_w), .ovf(ovf_w), .ovf_sticky(ovf_sticky_w), .ovf_clr(ovf_clr),
    .ovf_cnt(ovf_cnt_w));

  fp_addsub_pipe #(.RND(0)) dut_t (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_t),
    .A(A), .B(B), .op(op), .out_valid(out_valid_t), .out_ready(out_ready),
    .out(out_t), .ovf(ovf_t), .ovf_sticky(ovf_sticky_t), .ovf_clr(ovf_clr),
    .ovf_cnt(ovf_cnt_t));

  // Hand-computed vectors: A, B, op, rounded out/ovf, truncated out/ovf, wrapped out.
  localparam int N = 12;
  logic [17:0] va [N] = '{18'h00003, 18'h00002, 18'h3FFFD, 18'h3FFFE, 18'h003FF, 18'h1FFFC,
                          18'h1FFFE, 18'h20000, 18'h20000, 18'h00600, 18'h00000, 18'h1FC00};
  logic [17:0] vb [N] = '{18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0,
                          18'h0, 18'h0, 18'h3FF00, 18'h00200, 18'h20000, 18'h00400};
  logic        vop[N] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
  logic [15:0] er [N] = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0000, 16'h0100, 16'h7FFF,
                          16'h7FFF, 16'h8000, 16'h8000, 16'h0100, 16'h7FFF, 16'h7FFF};
  logic        eor[N] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1};
  logic [15:0] et [N] = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h00FF, 16'h7FFF,
                          16'h7FFF, 16'h8000, 16'h8000, 16'h0100, 16'h7FFF, 16'h7FFF};
  logic        eot[N] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1};
  logic [15:0] ew [N] = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0000, 16'h0100, 16'h7FFF,
                          16'h8000, 16'h8000, 16'h7FC0, 16'h0100, 16'h8000, 16'h8000};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; A = '0; B = '0; op = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    tick(); tick();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b exp 0", out_valid); else n_pass++;
    n_chk++; if (out !== 16'h0000) $display("FAIL rst_out: got %h exp 0000", out); else n_pass++;
    n_chk++; if (ovf !== 1'b0) $display("FAIL rst_ovf: got %b exp 0", ovf); else n_pass++;
    n_chk++; if (ovf_sticky !== 1'b0) $display("FAIL rst_sticky: got %b exp 0", ovf_sticky); else n_pass++;
    n_chk++; if (ovf_cnt !== 8'h00) $display("FAIL rst_cnt: got %h exp 00", ovf_cnt); else n_pass++;
    rstn = 1'b1;
    tick();
    n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b exp 1", in_ready); else n_pass++;
  endtask

  task automatic test_sat_add();
    in_valid = 1'b1; A = 18'h1FC00; B = 18'h00400; op = 1'b0;
    tick();
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL sat_lat1: got %b exp 0", out_valid); else n_pass++;
    tick();
    n_chk++; if (out_valid !== 1'b1) $display("FAIL sat_lat2: got %b exp 1", out_valid); else n_pass++;
    n_chk++; if (out !== 16'h7FFF) $display("FAIL sat_out: got %h exp 7fff", out); else n_pass++;
    n_chk++; if (ovf !== 1'b1) $display("FAIL sat_ovf: got %b exp 1", ovf); else n_pass++;
    n_chk++; if (out_w !== 16'h8000) $display("FAIL wrap_out: got %h exp 8000", out_w); else n_pass++;
    n_chk++; if (ovf_w !== 1'b1) $display("FAIL wrap_ovf: got %b exp 1", ovf_w); else n_pass++;
    tick();
    n_chk++; if (ovf_sticky !== 1'b1) $display("FAIL sat_sticky: got %b exp 1", ovf_sticky); else n_pass++;
    n_chk++; if (ovf_cnt !== 8'h01) $display("FAIL sat_cnt: got %h exp 01", ovf_cnt); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL sat_drain: got %b exp 0", out_valid); else n_pass++;
  endtask

  // Vectors streamed one per cycle; result i appears two cycles after drive.
  task automatic test_back_to_back();
    for (int i = 0; i <= N; i++) begin
      if (i < N) begin
        in_valid = 1'b1; A = va[i]; B = vb[i]; op = vop[i];
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        int j;
        j = i - 1;
        n_chk++; if (out_valid !== 1'b1) $display("FAIL b2b[%0d] valid: got %b exp 1", j, out_valid); else n_pass++;
        n_chk++; if (out !== er[j]) $display("FAIL b2b[%0d] rnd_out: got %h exp %h", j, out, er[j]); else n_pass++;
        n_chk++; if (ovf !== eor[j]) $display("FAIL b2b[%0d] rnd_ovf: got %b exp %b", j, ovf, eor[j]); else n_pass++;
        n_chk++; if (out_t !== et[j]) $display("FAIL b2b[%0d] trunc_out: got %h exp %h", j, out_t, et[j]); else n_pass++;
        n_chk++; if (ovf_t !== eot[j]) $display("FAIL b2b[%0d] trunc_ovf: got %b exp %b", j, ovf_t, eot[j]); else n_pass++;
        n_chk++; if (out_w !== ew[j]) $display("FAIL b2b[%0d] wrap_out: got %h exp %h", j, out_w, ew[j]); else n_pass++;
      end
    end
    tick();
  endtask

  task automatic test_counter();
    // Table contributed four overflow beats on top of the earlier one.
    n_chk++; if (ovf_cnt !== 8'h05) $display("FAIL cnt_pre: got %h exp 05", ovf_cnt); else n_pass++;
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    n_chk++; if (ovf_cnt !== 8'h00) $display("FAIL clr_cnt: got %h exp 00", ovf_cnt); else n_pass++;
    n_chk++; if (ovf_sticky !== 1'b0) $display("FAIL clr_sticky: got %b exp 0", ovf_sticky); else n_pass++;
    in_valid = 1'b1; A = 18'h1FC00; B = 18'h00400; op = 1'b0;
    repeat (300) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    n_chk++; if (ovf_cnt !== 8'hFF) $display("FAIL cnt_sat: got %h exp ff", ovf_cnt); else n_pass++;
    n_chk++; if (ovf_sticky !== 1'b1) $display("FAIL cnt_sticky: got %b exp 1", ovf_sticky); else n_pass++;
    in_valid = 1'b1; tick(); in_valid = 1'b0; tick();
    n_chk++; if (ovf !== 1'b1) $display("FAIL clrhit_ovf: got %b exp 1", ovf); else n_pass++;
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    n_chk++; if (ovf_cnt !== 8'h01) $display("FAIL clrhit_cnt: got %h exp 01", ovf_cnt); else n_pass++;
    n_chk++; if (ovf_sticky !== 1'b1) $display("FAIL clrhit_sticky: got %b exp 1", ovf_sticky); else n_pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; B = '0; op = 1'b0; in_valid = 1'b1;
    A = 18'h00400; #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_rdy0: got %b exp 1", in_ready); else n_pass++;
    tick();
    A = 18'h00800; #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_rdy1: got %b exp 1", in_ready); else n_pass++;
    tick();
    A = 18'h00C00; #1;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_rdy2: got %b exp 0", in_ready); else n_pass++;
    tick();
    n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_rdy3: got %b exp 0", in_ready); else n_pass++;
    n_chk++; if (out_valid !== 1'b1) $display("FAIL bp_valid: got %b exp 1", out_valid); else n_pass++;
    n_chk++; if (out !== 16'h0100) $display("FAIL bp_out1: got %h exp 0100", out); else n_pass++;
    tick();
    n_chk++; if (out !== 16'h0100) $display("FAIL bp_hold: got %h exp 0100", out); else n_pass++;
    out_ready = 1'b1; #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_release: got %b exp 1", in_ready); else n_pass++;
    tick();
    in_valid = 1'b0;
    n_chk++; if (out !== 16'h0200) $display("FAIL bp_out2: got %h exp 0200", out); else n_pass++;
    tick();
    n_chk++; if (out !== 16'h0300) $display("FAIL bp_out3: got %h exp 0300", out); else n_pass++;
    tick();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL bp_drain: got %b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0; in_valid = 1'b1; A = 18'h00400; B = '0; op = 1'b0;
    tick();
    A = 18'h00800;
    tick();
    in_valid = 1'b0;
    tick();
    n_chk++; if (out_valid !== 1'b1) $display("FAIL ms_stalled: got %b exp 1", out_valid); else n_pass++;
    rstn = 1'b0; tick(); rstn = 1'b1;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL ms_valid: got %b exp 0", out_valid); else n_pass++;
    n_chk++; if (out !== 16'h0000) $display("FAIL ms_out: got %h exp 0000", out); else n_pass++;
    n_chk++; if (ovf_cnt !== 8'h00) $display("FAIL ms_cnt: got %h exp 00", ovf_cnt); else n_pass++;
    out_ready = 1'b1; #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL ms_rdy: got %b exp 1", in_ready); else n_pass++;
    tick(); tick();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL ms_dropped: got %b exp 0", out_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sat_add();
    test_back_to_back();
    test_counter();
    test_backpressure();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
